// File: rtl/keypoint_scan_ctrl_pkg.sv
// Shared SIFT types: controller state encoding, derived-width helpers and the
// {row, col} keypoint record consumed by downstream descriptor blocks.
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } kp_state_t;

  // Never narrower than one bit, so degenerate sizes still give legal vectors.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int row_w(input int img_rows);
    return width_of(img_rows);
  endfunction

  function automatic int col_w(input int img_cols);
    return width_of(img_cols);
  endfunction

  function automatic int addr_w(input int kp_depth);
    return width_of(kp_depth);
  endfunction

  typedef struct packed {
    logic [8:0] row;
    logic [9:0] col;
  } kp_rec_t;

endpackage

// File: rtl/keypoint_scan_ctrl_if.sv
// Bus bundle between the keypoint scan controller (slave side) and its host,
// the scale-space SRAMs, the detect datapath and the keypoint SRAMs.
interface keypoint_scan_ctrl_if
  import sift_pkg::*;
#(
  parameter int IMG_ROWS   = 480,
  parameter int IMG_COLS   = 640,
  parameter int NUM_SCALES = 2,
  parameter int KP_DEPTH   = 2048
);
  localparam int ROW_W  = row_w(IMG_ROWS);
  localparam int COL_W  = col_w(IMG_COLS);
  localparam int ADDR_W = addr_w(KP_DEPTH);

  // Handshake: start is accepted only while busy is low; busy stays high from
  // the cycle after acceptance until the cycle after the one-cycle done pulse.
  // abort returns to idle with no done. Each kp_we bit is a one-cycle write
  // qualifier for its scale's kp_addr/kp_din slice; there is no back-pressure.
  logic                               start;
  logic                               abort;
  logic                               busy;
  logic                               done;
  logic                               rd_en;
  logic [ROW_W-1:0]                   row_addr;
  logic                               buffer_we;
  logic [NUM_SCALES*IMG_COLS-1:0]     cand_flags;
  logic [NUM_SCALES-1:0]              kp_we;
  logic [NUM_SCALES*ADDR_W-1:0]       kp_addr;
  logic [NUM_SCALES*(ROW_W+COL_W)-1:0] kp_din;
  logic [NUM_SCALES*(ADDR_W+1)-1:0]   kp_count;
  logic [NUM_SCALES-1:0]              overflow;
  kp_state_t                          state;

  modport master (
    output start, abort, cand_flags,
    input  busy, done, rd_en, row_addr, buffer_we,
    input  kp_we, kp_addr, kp_din, kp_count, overflow, state
  );

  modport slave (
    input  start, abort, cand_flags,
    output busy, done, rd_en, row_addr, buffer_we,
    output kp_we, kp_addr, kp_din, kp_count, overflow, state
  );

endinterface

// File: rtl/keypoint_scan_ctrl_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the least significant one
// plus a flag telling whether any bit is set.
module lsb_priority_enc #(
  parameter int WIDTH = 640,
  parameter int IDX_W = 10
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walking downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypoint_scan_ctrl.sv
// Row sequencer and keypoint compactor: fetches each image row, captures the
// per-scale flag vectors and serially writes flagged columns as {row, col}.
module keypoint_scan_ctrl
  import sift_pkg::*;
#(
  parameter int IMG_ROWS   = 480,
  parameter int IMG_COLS   = 640,
  parameter int NUM_SCALES = 2,
  parameter int KP_DEPTH   = 2048,
  parameter int RD_LAT     = 1
) (
  input logic                clk,
  input logic                rst_n,
  keypoint_scan_ctrl_if.slave bus
);

  localparam int ROW_W  = row_w(IMG_ROWS);
  localparam int COL_W  = col_w(IMG_COLS);
  localparam int ADDR_W = addr_w(KP_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int REC_W  = ROW_W + COL_W;
  localparam int WAIT_W = width_of(RD_LAT);
  localparam logic [IMG_COLS-1:0] INNER = {1'b0, {(IMG_COLS-2){1'b1}}, 1'b0};

  kp_state_t                             state_q, state_d;
  logic [WAIT_W-1:0]                     wait_q, wait_d;
  logic [ROW_W-1:0]                      row_q, row_d;
  logic [NUM_SCALES-1:0][IMG_COLS-1:0]   mask_q, mask_d;
  logic [NUM_SCALES-1:0][CNT_W-1:0]      count_q, count_d;
  logic [NUM_SCALES-1:0][ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_SCALES-1:0][REC_W-1:0]      din_q, din_d;
  logic [NUM_SCALES-1:0]                 we_q, we_d;
  logic [NUM_SCALES-1:0]                 ovf_q, ovf_d;
  logic                                  busy_q, done_q, rd_en_q, bwe_q;

  logic [NUM_SCALES-1:0][COL_W-1:0]      lsb_idx;
  logic [NUM_SCALES-1:0]                 lsb_any;

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_enc
    lsb_priority_enc #(.WIDTH(IMG_COLS), .IDX_W(COL_W)) u_enc (
      .vec_i (mask_q[s]),
      .idx_o (lsb_idx[s]),
      .any_o (lsb_any[s])
    );
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    row_d   = row_q;
    mask_d  = mask_q;
    count_d = count_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ovf_d   = ovf_q;
    we_d    = '0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_FETCH;
            row_d   = '0;
            count_d = '0;
            addr_d  = '0;
            ovf_d   = '0;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_W'(RD_LAT - 1)) begin
            // The first two rows only prime the line buffers.
            if (row_q >= ROW_W'(2)) begin
              state_d = ST_SCAN;
              for (int s = 0; s < NUM_SCALES; s++)
                mask_d[s] = bus.cand_flags[s*IMG_COLS +: IMG_COLS] & INNER;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_SCAN: begin
          for (int s = 0; s < NUM_SCALES; s++) begin
            if (lsb_any[s]) begin
              if (count_q[s] < CNT_W'(KP_DEPTH)) begin
                we_d[s]               = 1'b1;
                addr_d[s]             = count_q[s][ADDR_W-1:0];
                din_d[s]              = {row_q - ROW_W'(1), lsb_idx[s]};
                count_d[s]            = count_q[s] + 1'b1;
                mask_d[s][lsb_idx[s]] = 1'b0;
              end else begin
                ovf_d[s]  = 1'b1;
                mask_d[s] = '0;
              end
            end
          end
          if (mask_d == '0) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (row_q == ROW_W'(IMG_ROWS - 1)) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      row_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      bwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      rd_en_q <= (state_d == ST_FETCH);
      bwe_q   <= (state_d == ST_SHIFT);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.row_addr  = row_q;
  assign bus.buffer_we = bwe_q;
  assign bus.kp_we     = we_q;
  assign bus.kp_addr   = addr_q;
  assign bus.kp_din    = din_q;
  assign bus.kp_count  = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.state     = state_q;

endmodule
